// File: rtl/operand_fetch_if.sv
// Request/result handshake bundle for operand_fetch.
// master = upstream requester and downstream consumer; slave = the fetch sequencer.
interface operand_fetch_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);
  logic              req_valid;
  logic              req_ready;
  logic [REG_AW-1:0] req_rn;
  logic [REG_AW-1:0] req_rm;
  logic              req_one;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;

  modport master (
    output req_valid, req_rn, req_rm, req_one, out_ready,
    input  req_ready, out_valid, a_out, b_out
  );

  modport slave (
    input  req_valid, req_rn, req_rm, req_one, out_ready,
    output req_ready, out_valid, a_out, b_out
  );
endinterface

// File: rtl/operand_fetch.sv
// Two-operand fetch sequencer in front of a single-read-port register file.
// Define OPFETCH_FWD_EN to forward a same-cycle register-file write into the captured operand.
module operand_fetch #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  operand_fetch_if.slave    bus,
  output logic [REG_AW-1:0] readnum,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              rf_write,
  input  logic [REG_AW-1:0] rf_wnum,
  input  logic [DATA_W-1:0] rf_wdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_A  = 2'd1,
    RD_B  = 2'd2,
    VALID = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [REG_AW-1:0] rn_q, rn_d;
  logic [REG_AW-1:0] rm_q, rm_d;
  logic              one_q, one_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              out_valid_q, out_valid_d;
  logic [REG_AW-1:0] readnum_q, readnum_d;
  logic [DATA_W-1:0] cap_data;

`ifdef OPFETCH_FWD_EN
  // A write landing on the same edge would otherwise hand back the stale register.
  always_comb begin
    cap_data = rf_data;
    if (rf_write && (rf_wnum == readnum_q)) begin
      cap_data = rf_wdata;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{rf_write, rf_wnum, rf_wdata};
  always_comb begin
    cap_data = rf_data;
  end
`endif

  always_comb begin
    state_d     = state_q;
    rn_d        = rn_q;
    rm_d        = rm_q;
    one_d       = one_q;
    a_d         = a_q;
    b_d         = b_q;
    out_valid_d = 1'b0;
    readnum_d   = '0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          rn_d    = bus.req_rn;
          rm_d    = bus.req_rm;
          one_d   = bus.req_one;
          state_d = RD_A;
        end
      end
      RD_A: begin
        a_d = cap_data;
        if (one_q) begin
          b_d         = '0;
          state_d     = VALID;
          out_valid_d = 1'b1;
        end else if (rm_q == rn_q) begin
          b_d         = cap_data;
          state_d     = VALID;
          out_valid_d = 1'b1;
        end else begin
          state_d = RD_B;
        end
      end
      RD_B: begin
        b_d         = cap_data;
        state_d     = VALID;
        out_valid_d = 1'b1;
      end
      VALID: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // readnum is decoded from the next state so it comes straight from a flop.
    case (state_d)
      RD_A:    readnum_d = rn_d;
      RD_B:    readnum_d = rm_d;
      default: readnum_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rn_q        <= '0;
      rm_q        <= '0;
      one_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      readnum_q   <= '0;
    end else begin
      state_q     <= state_d;
      rn_q        <= rn_d;
      rm_q        <= rm_d;
      one_q       <= one_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
      readnum_q   <= readnum_d;
    end
  end

  assign readnum       = readnum_q;
  assign bus.req_ready = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;

endmodule
